phase_generator: RTL

Generates the four-phase instruction cycle (FETCH, DECODE, EXECUTE, UPDATE) that drives the sequence controller's PHASE input, one phase per clock. It also provides run/halt/single-step control, EXECUTE stretching for slow memory, a wait timeout, and a retired-instruction counter. It sits directly upstream of the sequence controller and is the only source of PHASE in the processor.

---
 rtl/phase_generator.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/phase_generator.sv
// Four-phase instruction cycle generator (FETCH/DECODE/EXECUTE/UPDATE) with run/halt,
// EXECUTE stretching, wait timeout and retired-instruction counter. Optional: PHASE_STEP_EN.
package phasepackage;
  typedef enum logic [1:0] {
    FETCH   = 2'b00,
    DECODE  = 2'b01,
    EXECUTE = 2'b10,
    UPDATE  = 2'b11
  } phase_t;
endpackage

module phase_generator
  import phasepackage::*;
#(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_run,
  input  logic             i_halt_req,
  input  logic             i_step_req,
  input  logic             i_wait,
  output phase_t           o_phase,
  output logic             o_phase_valid,
  output logic             o_halted,
  output logic             o_instr_done,
  output logic [CNT_W-1:0] o_instr_count,
  output logic             o_wait_timeout
);

  typedef enum logic [2:0] {
    ST_HALT,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_UPDATE
  } state_t;

  state_t           r_state;
  phase_t           r_phase;
  logic             r_phase_valid;
  logic             r_halted;
  logic             r_instr_done;
  logic [CNT_W-1:0] r_instr_count;
  logic             r_wait_timeout;
  logic             r_halt_pending;
  logic [7:0]       r_wait_cnt;

  logic             w_step_go;
  logic             w_step_mode;
  logic             w_stop_at_update;
  logic             w_leave_execute;

`ifdef PHASE_STEP_EN
  logic r_step_mode;
  assign w_step_go   = i_step_req;
  assign w_step_mode = r_step_mode;
`else
  logic w_unused_step;
  assign w_step_go     = 1'b0;
  assign w_step_mode   = 1'b0;
  assign w_unused_step = i_step_req;
`endif

  // A halt request arriving in the UPDATE cycle itself still stops at this boundary.
  assign w_stop_at_update = w_step_mode || r_halt_pending || i_halt_req || !i_run;
  assign w_leave_execute  = !i_wait || (r_wait_cnt == 8'(MAX_WAIT));

  // Outputs are loaded together with the next state so every output is a flop.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state        <= ST_HALT;
      r_phase        <= FETCH;
      r_phase_valid  <= 1'b0;
      r_halted       <= 1'b1;
      r_instr_done   <= 1'b0;
      r_instr_count  <= '0;
      r_wait_timeout <= 1'b0;
      r_halt_pending <= 1'b0;
      r_wait_cnt     <= '0;
`ifdef PHASE_STEP_EN
      r_step_mode    <= 1'b0;
`endif
    end else begin
      r_instr_done <= 1'b0;
      if (r_state != ST_HALT && i_halt_req) r_halt_pending <= 1'b1;

      unique case (r_state)
        ST_HALT: begin
          if (i_run || w_step_go) begin
            r_state       <= ST_FETCH;
            r_phase       <= FETCH;
            r_phase_valid <= 1'b1;
            r_halted      <= 1'b0;
`ifdef PHASE_STEP_EN
            r_step_mode   <= !i_run;
`endif
          end
        end
        ST_FETCH: begin
          r_state <= ST_DECODE;
          r_phase <= DECODE;
        end
        ST_DECODE: begin
          r_state <= ST_EXECUTE;
          r_phase <= EXECUTE;
        end
        ST_EXECUTE: begin
          if (w_leave_execute) begin
            r_state       <= ST_UPDATE;
            r_phase       <= UPDATE;
            r_wait_cnt    <= '0;
            r_instr_done  <= 1'b1;
            r_instr_count <= r_instr_count + CNT_W'(1);
            if (i_wait) r_wait_timeout <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        ST_UPDATE: begin
          if (w_stop_at_update) begin
            r_state        <= ST_HALT;
            r_phase        <= FETCH;
            r_phase_valid  <= 1'b0;
            r_halted       <= 1'b1;
            r_halt_pending <= 1'b0;
`ifdef PHASE_STEP_EN
            r_step_mode    <= 1'b0;
`endif
          end else begin
            r_state <= ST_FETCH;
            r_phase <= FETCH;
          end
        end
        default: begin
          r_state       <= ST_HALT;
          r_phase       <= FETCH;
          r_phase_valid <= 1'b0;
          r_halted      <= 1'b1;
        end
      endcase
    end
  end

  assign o_phase        = r_phase;
  assign o_phase_valid  = r_phase_valid;
  assign o_halted       = r_halted;
  assign o_instr_done   = r_instr_done;
  assign o_instr_count  = r_instr_count;
  assign o_wait_timeout = r_wait_timeout;

endmodule
